// File: rtl/axistream_forwarder_bytelen_if.sv
`default_nettype none
// ============================================================================
// axistream_forwarder_bytelen_if : AXI-Stream bundle (TDATA/TKEEP/TVALID/TLAST/TREADY)
// Revision 1.0
// ============================================================================
interface axistream_forwarder_bytelen_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0]   TDATA;
    logic [DATA_WIDTH/8-1:0] TKEEP;
    logic                    TVALID;
    logic                    TLAST;
    logic                    TREADY;

    modport master (
        output TDATA, TKEEP, TVALID, TLAST,
        input  TREADY
    );

    modport slave (
        input  TDATA, TKEEP, TVALID, TLAST,
        output TREADY
    );
endinterface
`default_nettype wire

// File: rtl/axistream_forwarder_bytelen.sv
`default_nettype none
// ============================================================================
// axistream_forwarder_bytelen : streams one packetmem packet as AXIS with TKEEP
// Revision 1.0
// ============================================================================
module axistream_forwarder_bytelen #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 9,
    parameter bit PESSIMISTIC = 1'b0,
    localparam int BYTES      = DATA_WIDTH / 8,
    localparam int BSEL       = $clog2(BYTES),
    localparam int PLEN_WIDTH = ADDR_WIDTH + BSEL + 1
) (
    input  wire                          clk,
    input  wire                          rst,
    axistream_forwarder_bytelen_if.master axis,
    output logic [ADDR_WIDTH-1:0]        forwarder_rd_addr,
    input  wire  [DATA_WIDTH-1:0]        forwarder_rd_data,
    output logic                         forwarder_rd_en,
    output logic                         forwarder_done,
    input  wire                          ready_for_forwarder,
    input  wire  [PLEN_WIDTH-1:0]        len_to_forwarder
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state, state_next;
    logic                    ready_int;
    logic [PLEN_WIDTH-1:0]   len_int;
    logic [PLEN_WIDTH-1:0]   len_m1;
    logic [BSEL-1:0]         len_rem;
    logic [BYTES-1:0]        keep_calc;
    logic [ADDR_WIDTH-1:0]   last_addr, last_addr_next;
    logic [BYTES-1:0]        last_keep, last_keep_next;
    logic [ADDR_WIDTH-1:0]   rd_addr_next;
    logic                    rd_en_next;
    logic                    issue_last;
    logic                    inflight, inflight_last;
    logic                    push, pop, valid;
    logic [1:0]              count;
    logic                    wptr, rptr;
    logic [2:0]              credit_used;
    logic [DATA_WIDTH-1:0]   buf_data [2];
    logic                    buf_last [2];
    logic                    unused_len_bits;

    generate
        if (PESSIMISTIC) begin : g_pessimistic
            logic                  ready_q;
            logic [PLEN_WIDTH-1:0] len_q;
            // Dropping ready while done is high stops a stale ready from restarting us.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ready_q <= 1'b0;
                    len_q   <= '0;
                end else begin
                    ready_q <= ready_for_forwarder && !forwarder_done;
                    len_q   <= len_to_forwarder;
                end
            end
            assign ready_int = ready_q;
            assign len_int   = len_q;
        end else begin : g_direct
            assign ready_int = ready_for_forwarder;
            assign len_int   = len_to_forwarder;
        end
    endgenerate

    assign len_m1          = len_int - 1'b1;
    assign len_rem         = len_int[BSEL-1:0];
    assign unused_len_bits = ^{len_m1[PLEN_WIDTH-1], len_m1[BSEL-1:0]};

    always_comb begin
        keep_calc = '0;
        for (int b = 0; b < BYTES; b++) begin
            keep_calc[b] = (len_rem == '0) || (b < int'(len_rem));
        end
    end

    assign valid      = (count != 2'd0);
    assign pop        = valid && axis.TREADY;
    assign push       = inflight;
    assign issue_last = forwarder_rd_en && (forwarder_rd_addr == last_addr);

    // Words already committed: buffered, landing now, and requested this cycle.
    assign credit_used = {1'b0, count} + {2'b00, inflight} + {2'b00, forwarder_rd_en}
                       - {2'b00, pop};

    always_comb begin
        state_next     = state;
        rd_en_next     = 1'b0;
        rd_addr_next   = forwarder_rd_addr;
        last_addr_next = last_addr;
        last_keep_next = last_keep;
        if (forwarder_rd_en) begin
            rd_addr_next = forwarder_rd_addr + 1'b1;
        end
        case (state)
            S_IDLE: begin
                if (ready_int) begin
                    if (len_int != '0) begin
                        last_addr_next = len_m1[BSEL +: ADDR_WIDTH];
                        last_keep_next = keep_calc;
                        rd_addr_next   = '0;
                        rd_en_next     = 1'b1;
                        state_next     = S_READ;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_READ: begin
                rd_en_next = !issue_last && (credit_used < 3'd2);
                if (issue_last) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && axis.TLAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                rd_addr_next = '0;
                state_next   = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            forwarder_rd_en   <= 1'b0;
            forwarder_rd_addr <= '0;
            last_addr         <= '0;
            last_keep         <= '0;
            inflight          <= 1'b0;
            inflight_last     <= 1'b0;
            count             <= 2'd0;
            wptr              <= 1'b0;
            rptr              <= 1'b0;
        end else begin
            state             <= state_next;
            forwarder_rd_en   <= rd_en_next;
            forwarder_rd_addr <= rd_addr_next;
            last_addr         <= last_addr_next;
            last_keep         <= last_keep_next;
            inflight          <= forwarder_rd_en;
            inflight_last     <= issue_last;
            if (push) begin
                wptr <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wptr] <= forwarder_rd_data;
            buf_last[wptr] <= inflight_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && (count == 2'd2)));
        end
    end

    // Outputs are gated by valid so an empty buffer presents all zeros.
    assign axis.TVALID    = valid;
    assign axis.TDATA     = valid ? buf_data[rptr] : '0;
    assign axis.TLAST     = valid && buf_last[rptr];
    assign axis.TKEEP     = !valid ? '0 : (buf_last[rptr] ? last_keep : {BYTES{1'b1}});
    assign forwarder_done = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_axistream_forwarder_bytelen.sv
`default_nettype none
// ============================================================================
// tb_axistream_forwarder_bytelen : scoreboard bench, direct and pessimistic instances
// Revision 1.0
// ============================================================================
module tb_axistream_forwarder_bytelen;
    localparam int DW    = 64;
    localparam int AW    = 9;
    localparam int BYTES = DW / 8;
    localparam int PLW   = AW + 3 + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]     tready;
    logic [1:0]     ready_s;
    logic [PLW-1:0] len_s [2];
    logic [DW-1:0]  rd_data [2];
    logic           rmode;
    int             tag [2];

    wire [1:0]       rd_en, done, tvalid, tlast;
    wire [DW-1:0]    tdata [2];
    wire [BYTES-1:0] tkeep [2];
    wire [AW-1:0]    rd_addr [2];

    int n_checks = 0;
    int n_pass   = 0;
    int hs_cnt [2];
    int done_cnt [2];
    logic [73:0] exp_q [$];
    logic [1:0]  stall_prev, last_pend;
    logic [73:0] held [2];

    axistream_forwarder_bytelen_if #(.DATA_WIDTH(DW)) axis0 ();
    axistream_forwarder_bytelen_if #(.DATA_WIDTH(DW)) axis1 ();

    assign axis0.TREADY = tready[0];
    assign axis1.TREADY = tready[1];
    assign tvalid[0] = axis0.TVALID;
    assign tvalid[1] = axis1.TVALID;
    assign tlast[0]  = axis0.TLAST;
    assign tlast[1]  = axis1.TLAST;
    assign tdata[0]  = axis0.TDATA;
    assign tdata[1]  = axis1.TDATA;
    assign tkeep[0]  = axis0.TKEEP;
    assign tkeep[1]  = axis1.TKEEP;

    axistream_forwarder_bytelen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PESSIMISTIC(1'b0)) dut (
        .clk(clk), .rst(rst), .axis(axis0),
        .forwarder_rd_addr(rd_addr[0]), .forwarder_rd_data(rd_data[0]),
        .forwarder_rd_en(rd_en[0]), .forwarder_done(done[0]),
        .ready_for_forwarder(ready_s[0]), .len_to_forwarder(len_s[0])
    );

    axistream_forwarder_bytelen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PESSIMISTIC(1'b1)) dut_p (
        .clk(clk), .rst(rst), .axis(axis1),
        .forwarder_rd_addr(rd_addr[1]), .forwarder_rd_data(rd_data[1]),
        .forwarder_rd_en(rd_en[1]), .forwarder_done(done[1]),
        .ready_for_forwarder(ready_s[1]), .len_to_forwarder(len_s[1])
    );

    function automatic logic [DW-1:0] word_at(input int k, input int t, input int a);
        logic [31:0] mix;
        mix = (32'(a) * 32'h9E37_79B1) ^ 32'(t);
        return {8'(8'hD0 + k), 8'(t), 16'(a), mix};
    endfunction

    task automatic check_eq(input string tag_s, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h required %0h", tag_s, obs, exp);
        end
    endtask

    // Packetmem model: registered read, data valid the cycle after rd_en.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rd_en[k]) rd_data[k] <= word_at(k, tag[k], int'(rd_addr[k]));
        end
    end

    initial begin
        tready = 2'b11;
        forever begin
            @(posedge clk); #1;
            tready[0] = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
            tready[1] = 1'b1;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                stall_prev[k] = 1'b0;
                last_pend[k]  = 1'b0;
            end else begin
                if (stall_prev[k])
                    check_eq("stall_hold", 128'({1'b1, tlast[k], tkeep[k], tdata[k]}), 128'(held[k]));
                if (last_pend[k])
                    check_eq("done_timing", 128'(done[k]), 128'(1));
                last_pend[k] = 1'b0;
                if (done[k]) done_cnt[k]++;
                if (tvalid[k] && tready[k]) begin
                    hs_cnt[k]++;
                    if (exp_q.size() == 0) begin
                        check_eq("extra_beat", 128'(exp_q.size()), 128'(1));
                    end else begin
                        check_eq("beat", 128'({1'(k), tlast[k], tkeep[k], tdata[k]}),
                                 128'(exp_q.pop_front()));
                    end
                    if (tlast[k]) last_pend[k] = 1'b1;
                end
                stall_prev[k] = tvalid[k] && !tready[k];
                held[k] = {tvalid[k], tlast[k], tkeep[k], tdata[k]};
            end
        end
    end

    task automatic start_packet(input int k, input int len_b);
        int nb;
        int rem;
        logic [BYTES-1:0] lk;
        nb  = (len_b + BYTES - 1) / BYTES;
        rem = len_b % BYTES;
        lk  = (rem == 0) ? {BYTES{1'b1}} : BYTES'((1 << rem) - 1);
        tag[k] = tag[k] + 1;
        for (int i = 0; i < nb; i++) begin
            exp_q.push_back({1'(k), (i == nb - 1), (i == nb - 1) ? lk : {BYTES{1'b1}},
                             word_at(k, tag[k], i)});
        end
        len_s[k]   = PLW'(len_b);
        ready_s[k] = 1'b1;
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done[k] && n < 3000);
        check_eq("done_seen", 128'(done[k]), 128'(1));
    endtask

    task automatic run_packet(input int len_b);
        int h0;
        int d0;
        h0 = hs_cnt[0];
        d0 = done_cnt[0];
        start_packet(0, len_b);
        wait_done(0);
        ready_s[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("done_once", 128'(done_cnt[0] - d0), 128'(1));
        check_eq("handshakes", 128'(hs_cnt[0] - h0), 128'((len_b + BYTES - 1) / BYTES));
        check_eq("queue_empty", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic check_reset_outputs(input int k);
        check_eq("reset_out", 128'({tvalid[k], tlast[k], tkeep[k], tdata[k], rd_en[k], rd_addr[k], done[k]}),
                 128'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish required finish");
        $fatal(1);
    end

    initial begin
        int h0;
        int d0;
        int n;
        rst = 1'b1;
        rmode = 1'b0;
        ready_s = 2'b00;
        len_s[0] = '0;
        len_s[1] = '0;
        tag[0] = 0;
        tag[1] = 0;
        hs_cnt[0] = 0;
        hs_cnt[1] = 0;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        stall_prev = 2'b00;
        last_pend = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Full beats, partial final beats, single-byte and 1-byte-over boundaries.
        run_packet(64);
        run_packet(13);
        run_packet(1);
        run_packet(8);
        run_packet(65);
        run_packet(7);

        rmode = 1'b1;
        run_packet(64);
        run_packet(100);
        rmode = 1'b0;

        run_packet(0);

        // Reset while beat 3 of an 8-beat packet is on the bus.
        h0 = hs_cnt[0];
        d0 = done_cnt[0];
        start_packet(0, 64);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while ((hs_cnt[0] - h0) < 2 && n < 200);
        check_eq("two_beats_before_rst", 128'(hs_cnt[0] - h0), 128'(2));
        ready_s[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs(0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("no_done_on_rst", 128'(done_cnt[0] - d0), 128'(0));
        run_packet(16);

        // Pessimistic instance, ready held across back-to-back packets.
        h0 = hs_cnt[1];
        d0 = done_cnt[1];
        start_packet(1, 24);
        wait_done(1);
        start_packet(1, 8);
        wait_done(1);
        ready_s[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("p_done_count", 128'(done_cnt[1] - d0), 128'(2));
        check_eq("p_handshakes", 128'(hs_cnt[1] - h0), 128'(4));
        check_eq("p_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
